// File: rtl/riscv_v_div.sv
// Iterative SIMD restoring divider with 8/16/32/64-bit lanes.
// Each lane produces one quotient bit per cycle. It returns the quotient or the remainder.
module riscv_v_div #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_OSIZES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kill,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_signed,
    input  logic                  is_rem,
    input  logic [NUM_OSIZES-1:0] osize_vector,
    input  logic [DATA_WIDTH-1:0] srca,
    input  logic [DATA_WIDTH-1:0] srcb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    localparam int MAX_LANES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   orig_q, orig_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [1:0]              sew_q, sew_d;
    logic                    zero_sz_q, zero_sz_d;
    logic                    signed_q, signed_d;
    logic                    rem_sel_q, rem_sel_d;
    logic [MAX_LANES-1:0]    qneg_q, qneg_d;
    logic [MAX_LANES-1:0]    rneg_q, rneg_d;
    logic [MAX_LANES-1:0]    dz_q, dz_d;
    logic [MAX_LANES-1:0]    ovf_q, ovf_d;

    logic [1:0]              dec_sew;
    logic                    dec_zero;
    logic [6:0]              lw;
    logic [5:0]              msb;
    logic [63:0]             mask;
    int                      nl;
    logic [63:0]             la, lb, lr, lo;
    logic                    sa, sb, qbit;
    logic [64:0]             r65;
    logic [DATA_WIDTH-1:0]   res;

    function automatic logic [63:0] lane_mask(input logic [6:0] w);
        lane_mask = (w == 7'd64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_lane(input logic [DATA_WIDTH-1:0] v,
                                             input logic [6:0] w, input int i);
        get_lane = 64'(v >> (i * int'(w))) & lane_mask(w);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] place(input logic [63:0] x,
                                                    input logic [6:0] w, input int i);
        place = DATA_WIDTH'(x & lane_mask(w)) << (i * int'(w));
    endfunction

    // Lowest set bit of the one-hot size select wins; all-zero falls back to byte timing.
    always_comb begin
        dec_sew  = 2'd0;
        dec_zero = 1'b1;
        for (int k = NUM_OSIZES - 1; k >= 0; k--) begin
            if (osize_vector[k]) begin
                dec_sew  = 2'(k);
                dec_zero = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        orig_d    = orig_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        sew_d     = sew_q;
        zero_sz_d = zero_sz_q;
        signed_d  = signed_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        lw        = 7'd8 << sew_q;
        msb       = 6'(lw - 7'd1);
        mask      = lane_mask(lw);
        nl        = DATA_WIDTH / int'(lw);
        la        = '0;
        lb        = '0;
        lr        = '0;
        lo        = '0;
        sa        = 1'b0;
        sb        = 1'b0;
        qbit      = 1'b0;
        r65       = '0;
        res       = '0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d       = srca;
                    orig_d    = srca;
                    b_d       = srcb;
                    signed_d  = is_signed;
                    rem_sel_d = is_rem;
                    sew_d     = dec_sew;
                    zero_sz_d = dec_zero;
                    state_d   = S_PREP;
                end
            end
            S_PREP: begin
                a_d    = '0;
                b_d    = '0;
                rem_d  = '0;
                qneg_d = '0;
                rneg_d = '0;
                dz_d   = '0;
                ovf_d  = '0;
                for (int i = 0; i < MAX_LANES; i++) begin
                    if (i < nl) begin
                        la = get_lane(a_q, lw, i);
                        lb = get_lane(b_q, lw, i);
                        sa = signed_q & la[msb];
                        sb = signed_q & lb[msb];
                        dz_d[i]   = (lb == 64'd0);
                        ovf_d[i]  = signed_q && (la == (64'd1 << msb)) && (lb == mask);
                        qneg_d[i] = sa ^ sb;
                        rneg_d[i] = sa;
                        a_d = a_d | place(sa ? (64'd0 - la) : la, lw, i);
                        b_d = b_d | place(sb ? (64'd0 - lb) : lb, lw, i);
                    end
                end
                cnt_d   = msb;
                state_d = S_ITER;
            end
            S_ITER: begin
                a_d   = '0;
                rem_d = '0;
                // 65-bit partial remainder keeps the carry out of an unsigned full-range lane.
                for (int i = 0; i < MAX_LANES; i++) begin
                    if (i < nl) begin
                        la  = get_lane(a_q, lw, i);
                        lb  = get_lane(b_q, lw, i);
                        lr  = get_lane(rem_q, lw, i);
                        r65 = {lr, la[msb]};
                        if (r65 >= {1'b0, lb}) begin
                            r65  = r65 - {1'b0, lb};
                            qbit = 1'b1;
                        end else begin
                            qbit = 1'b0;
                        end
                        rem_d = rem_d | place(r65[63:0], lw, i);
                        a_d   = a_d | place({la[62:0], qbit}, lw, i);
                    end
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                for (int i = 0; i < MAX_LANES; i++) begin
                    if (i < nl) begin
                        la = get_lane(a_q, lw, i);
                        lr = get_lane(rem_q, lw, i);
                        lo = get_lane(orig_q, lw, i);
                        if (qneg_q[i]) la = (64'd0 - la) & mask;
                        if (rneg_q[i]) lr = (64'd0 - lr) & mask;
                        if (dz_q[i]) begin
                            la = mask;
                            lr = lo;
                        end
                        if (ovf_q[i]) begin
                            la = lo;
                            lr = 64'd0;
                        end
                        res = res | place(rem_sel_q ? lr : la, lw, i);
                    end
                end
                result_d = zero_sz_q ? '0 : res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                out_valid = ~kill;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            orig_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            sew_q     <= '0;
            zero_sz_q <= 1'b0;
            signed_q  <= 1'b0;
            rem_sel_q <= 1'b0;
            qneg_q    <= '0;
            rneg_q    <= '0;
            dz_q      <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            orig_q    <= orig_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            sew_q     <= sew_d;
            zero_sz_q <= zero_sz_d;
            signed_q  <= signed_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result = result_q;

endmodule
